abajur_duty_ctrl: RTL and testbench

- Upstream stage of each lamp PWM channel; converts ambient-light ADC samples into the duty-cycle word the PWM generator consumes.
- Pipeline: block-averages 2^AVG_LOG2 samples, inverts and scales the average to a target brightness (darker room gives higher duty), applies hysteresis, then slews the output duty toward the target one LSB per ramp tick for a soft fade.
- One instance per channel, clocked from the same PLL output as its PWM generator.

---
 rtl/abajur_duty_ctrl.sv | 72 +++++++
 tb/tb_abajur_duty_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/abajur_duty_ctrl.sv
// abajur_duty_ctrl: ambient ADC samples -> averaged, inverted, hysteretic, slew-limited PWM duty (in: sample/valid/enable; out: duty/duty_valid/target/at_target)
module abajur_duty_ctrl #(
  parameter int ADC_W    = 12,
  parameter int DUTY_W   = 8,
  parameter int AVG_LOG2 = 3,
  parameter int STEP_DIV = 50000,
  parameter int HYST     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  sample,
  input  logic              enable,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic [DUTY_W-1:0] target,
  output logic              at_target
);
  localparam int AW = ADC_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int PW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [ADC_W-1:0] ADC_MAX = '1;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] avg_q, avg_d;
  logic avg_valid_q, avg_valid_d, last, tick;
  logic [PW-1:0] pre_q, pre_d;
  logic [DUTY_W-1:0] inv, diff, target_q, target_d, duty_q, duty_d;
  logic duty_valid_q, duty_valid_d;
  always_comb begin
    sum = acc_q + AW'(sample);
    last = sample_valid && cnt_q == CNT_LAST;
    acc_d = last ? '0 : sample_valid ? sum : acc_q;
    cnt_d = last ? '0 : sample_valid ? cnt_q + 1'b1 : cnt_q;
    avg_d = last ? ADC_W'(sum >> AVG_LOG2) : avg_q;
    avg_valid_d = last;
    inv = DUTY_W'((ADC_MAX - avg_q) >> (ADC_W - DUTY_W));
    diff = inv > target_q ? inv - target_q : target_q - inv;
    target_d = !enable ? '0 : (avg_valid_q && 32'(diff) >= HYST) ? inv : target_q;
    tick = pre_q == PRE_LAST;
    pre_d = tick ? '0 : pre_q + 1'b1;
    duty_d = !tick ? duty_q : duty_q < target_q ? duty_q + 1'b1 : duty_q > target_q ? duty_q - 1'b1 : duty_q;
    duty_valid_d = duty_d != duty_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      avg_valid_q <= 1'b0;
      pre_q <= '0;
      target_q <= '0;
      duty_q <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
      avg_valid_q <= avg_valid_d;
      pre_q <= pre_d;
      target_q <= target_d;
      duty_q <= duty_d;
      duty_valid_q <= duty_valid_d;
    end
  end
  assign duty = duty_q;
  assign duty_valid = duty_valid_q;
  assign target = target_q;
  assign at_target = duty_q == target_q;
endmodule

// File: tb/tb_abajur_duty_ctrl.sv
// tb_abajur_duty_ctrl: directed bench with a duty-step scoreboard for abajur_duty_ctrl
module tb_abajur_duty_ctrl;
  logic clk = 1'b0, rst, sample_valid, enable;
  logic [11:0] sample;
  logic [7:0] duty, target;
  logic duty_valid, at_target;
  int exp_q[$];
  int vectors = 0, miscompares = 0, pulses = 0, first_pulse = -1, last_pulse = -1, cyc = 0;
  abajur_duty_ctrl #(.STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .enable(enable),
    .duty(duty), .duty_valid(duty_valid), .target(target), .at_target(at_target)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (duty_valid === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL duty_step_unexpected duty=%0d expected no duty_valid", duty);
      end
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        assert (32'(duty) === 32'(e)) else begin
          miscompares++;
          $error("FAIL duty_step got=%0d expected=%0d", duty, e);
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample = v;
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask
  task automatic push_ramp(input int from, input int to);
    if (from <= to) for (int i = from; i <= to; i++) exp_q.push_back(i);
    else for (int i = from; i >= to; i--) exp_q.push_back(i);
  endtask
  task automatic wait_duty(input int v, input int bound);
    int n = 0;
    while (32'(duty) !== 32'(v) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_duty", 32'(duty), 32'(v));
  endtask
  initial begin
    rst = 1'b1;
    sample_valid = 1'($urandom);
    sample = 12'($urandom);
    enable = 1'($urandom);
    @(negedge clk);
    sample_valid = 1'($urandom);
    sample = 12'($urandom);
    @(negedge clk);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_target", 32'(target), 0);
    chk("rst_duty_valid", 32'(duty_valid), 0);
    chk("rst_at_target", 32'(at_target), 1);
    rst = 1'b0;
    sample_valid = 1'b0;
    enable = 1'b1;
    push_ramp(1, 255);
    send(12'h000, 8);
    @(negedge clk);
    chk("dark_target", 32'(target), 255);
    wait_duty(255, 1200);
    repeat (8) @(negedge clk);
    chk("dark_pulses", pulses, 255);
    chk("dark_period", last_pulse - first_pulse, 254 * 4);
    chk("dark_at_target", 32'(at_target), 1);
    chk("dark_queue", exp_q.size(), 0);
    pulses = 0;
    send(12'h030, 8);
    @(negedge clk);
    chk("hyst_hold_target", 32'(target), 255);
    repeat (20) @(negedge clk);
    chk("hyst_hold_duty", 32'(duty), 255);
    chk("hyst_hold_pulses", pulses, 0);
    push_ramp(254, 250);
    send(12'h050, 8);
    @(negedge clk);
    chk("hyst_move_target", 32'(target), 250);
    wait_duty(250, 100);
    repeat (8) @(negedge clk);
    chk("hyst_move_pulses", pulses, 5);
    chk("hyst_at_target", 32'(at_target), 1);
    push_ramp(249, 200);
    send(12'h370, 8);
    @(negedge clk);
    chk("to200_target", 32'(target), 200);
    wait_duty(200, 400);
    repeat (8) @(negedge clk);
    chk("to200_queue", exp_q.size(), 0);
    pulses = 0;
    push_ramp(199, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_target", 32'(target), 0);
    wait_duty(0, 1000);
    repeat (8) @(negedge clk);
    chk("disable_pulses", pulses, 200);
    chk("disable_at_target", 32'(at_target), 1);
    send(12'h000, 8);
    @(negedge clk);
    chk("disabled_avg_target", 32'(target), 0);
    repeat (4) @(negedge clk);
    chk("disabled_avg_target_late", 32'(target), 0);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("reenable_wait_target", 32'(target), 0);
    push_ramp(1, 32);
    send(12'hFFF, 7);
    send(12'h000, 1);
    @(negedge clk);
    chk("avg_arith_target", 32'(target), 32);
    wait_duty(32, 300);
    repeat (8) @(negedge clk);
    chk("avg_arith_queue", exp_q.size(), 0);
    push_ramp(33, 255);
    send(12'h000, 8);
    @(negedge clk);
    chk("reenable_target", 32'(target), 255);
    wait_duty(100, 400);
    send(12'hFFF, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_duty", 32'(duty), 0);
    chk("midrst_target", 32'(target), 0);
    chk("midrst_duty_valid", 32'(duty_valid), 0);
    chk("midrst_at_target", 32'(at_target), 1);
    exp_q.delete();
    rst = 1'b0;
    send(12'h000, 3);
    repeat (6) @(negedge clk);
    chk("partial_target", 32'(target), 0);
    chk("partial_duty", 32'(duty), 0);
    push_ramp(1, 255);
    send(12'h000, 5);
    @(negedge clk);
    chk("full_block_target", 32'(target), 255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
